// File: rtl/ui_click_decoder.sv
// Maps pointer position and debounced left-button activity to the on-screen button hit.
// Optional macro UI_SELECT_ON_PRESS_EN: select fires on press instead of release.
module ui_click_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       mouse_l,
    input  logic [3:0] play_valid,
    output logic [2:0] hover_id,
    output logic       sel_valid,
    output logic [2:0] sel_id
);

    typedef enum logic [2:0] {
        BTN_NONE   = 3'd0,
        BTN_STAGE1 = 3'd1,
        BTN_STAGE2 = 3'd2,
        BTN_STAGE3 = 3'd3,
        BTN_HELP   = 3'd4,
        BTN_NEXT   = 3'd5,
        BTN_BACK   = 3'd6,
        BTN_RETRY  = 3'd7
    } btn_t;

    typedef enum logic [3:0] {
        GS_TITLE    = 4'd0,
        GS_STAFF    = 4'd1,
        GS_STAGE1   = 4'd2,
        GS_SUCCESS1 = 4'd3,
        GS_STAGE2   = 4'd4,
        GS_SUCCESS2 = 4'd5,
        GS_STAGE3   = 4'd6,
        GS_SUCCESS3 = 4'd7,
        GS_FAIL     = 4'd8,
        GS_HELP     = 4'd9
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        WAIT_REL = 2'd2
    } sel_state_t;

    logic [8:0] px;
    logic [8:0] py;
    btn_t       hit_d;
    btn_t       hit_q;

    logic             sync1_q;
    logic             sync2_q;
    logic             db_d;
    logic             db_q;
    logic             db_prev_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             db_rise;
    logic             db_fall;

    sel_state_t  state_d;
    sel_state_t  state_q;
    btn_t        arm_id_d;
    btn_t        arm_id_q;
    logic        sel_valid_d;
    logic        sel_valid_q;
    btn_t        sel_id_d;
    btn_t        sel_id_q;
    logic [3:0]  prev_state_q;
    logic        unused_bits;

    assign px = mouse_x[9:1];
    assign py = mouse_y[9:1];
    assign unused_bits = ^{mouse_x[0], mouse_y[0], play_valid[1:0]};

    function automatic logic in_rng(input logic [8:0] v, input logic [8:0] lo, input logic [8:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    always_comb begin
        hit_d = BTN_NONE;
        case (state)
            GS_TITLE: if (in_rng(px, 9'd120, 9'd200)) begin
                if (in_rng(py, 9'd120, 9'd140))                        hit_d = BTN_STAGE1;
                else if (in_rng(py, 9'd150, 9'd170) && play_valid[2]) hit_d = BTN_STAGE2;
                else if (in_rng(py, 9'd180, 9'd200) && play_valid[3]) hit_d = BTN_STAGE3;
                else if (in_rng(py, 9'd210, 9'd230))                   hit_d = BTN_HELP;
            end
            GS_SUCCESS1, GS_SUCCESS2: if (in_rng(px, 9'd120, 9'd200)) begin
                if (in_rng(py, 9'd140, 9'd160))      hit_d = BTN_NEXT;
                else if (in_rng(py, 9'd180, 9'd200)) hit_d = BTN_BACK;
            end
            GS_SUCCESS3: if (in_rng(px, 9'd120, 9'd200) && in_rng(py, 9'd150, 9'd170)) hit_d = BTN_NEXT;
            GS_FAIL: if (in_rng(px, 9'd120, 9'd200)) begin
                if (in_rng(py, 9'd140, 9'd160))      hit_d = BTN_RETRY;
                else if (in_rng(py, 9'd180, 9'd200)) hit_d = BTN_BACK;
            end
            GS_STAFF: if (in_rng(px, 9'd120, 9'd200) && in_rng(py, 9'd180, 9'd200)) hit_d = BTN_BACK;
            GS_HELP:  if (in_rng(px, 9'd140, 9'd220) && in_rng(py, 9'd200, 9'd220)) hit_d = BTN_BACK;
            default:  hit_d = BTN_NONE;
        endcase
    end

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign db_rise = db_q & ~db_prev_q;
    assign db_fall = ~db_q & db_prev_q;

    always_comb begin
        state_d     = state_q;
        arm_id_d    = arm_id_q;
        sel_valid_d = 1'b0;
        sel_id_d    = sel_id_q;
        case (state_q)
            IDLE: if (db_rise) begin
`ifdef UI_SELECT_ON_PRESS_EN
                if (hit_q != BTN_NONE) begin
                    sel_valid_d = 1'b1;
                    sel_id_d    = hit_q;
                end
                state_d = WAIT_REL;
`else
                if (hit_q != BTN_NONE) begin
                    state_d  = ARMED;
                    arm_id_d = hit_q;
                end else begin
                    state_d = WAIT_REL;
                end
`endif
            end
            // A release always returns to IDLE, even on a screen change, so no click is swallowed.
            ARMED: if (db_fall) begin
                state_d = IDLE;
                if (hit_q == arm_id_q && state == prev_state_q) begin
                    sel_valid_d = 1'b1;
                    sel_id_d    = arm_id_q;
                end
            end else if (state != prev_state_q) begin
                state_d = WAIT_REL;
            end
            WAIT_REL: if (db_fall) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q        <= BTN_NONE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            db_prev_q    <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
            arm_id_q     <= BTN_NONE;
            sel_valid_q  <= 1'b0;
            sel_id_q     <= BTN_NONE;
            prev_state_q <= '0;
        end else begin
            hit_q        <= hit_d;
            sync1_q      <= mouse_l;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_prev_q    <= db_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            arm_id_q     <= arm_id_d;
            sel_valid_q  <= sel_valid_d;
            sel_id_q     <= sel_id_d;
            prev_state_q <= state;
        end
    end

    assign hover_id  = hit_q;
    assign sel_valid = sel_valid_q;
    assign sel_id    = sel_id_q;

endmodule

// File: tb/tb_ui_click_decoder.sv
// Directed bench for ui_click_decoder with DEBOUNCE_CYCLES=4.
// Build with UI_SELECT_ON_PRESS_EN defined to exercise the select-on-press variant.
module tb_ui_click_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       mouse_l;
    logic [3:0] play_valid;
    logic [2:0] hover_id;
    logic       sel_valid;
    logic [2:0] sel_id;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int pulses       = 0;
    int last_id      = 0;
    int pulse_cyc    = 0;
    int b2b          = 0;
    logic prev_sv    = 1'b0;

    always #5 clk = ~clk;

    ui_click_decoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .mouse_x   (mouse_x),
        .mouse_y   (mouse_y),
        .mouse_l   (mouse_l),
        .play_valid(play_valid),
        .hover_id  (hover_id),
        .sel_valid (sel_valid),
        .sel_id    (sel_id)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sel_valid === 1'b1) begin
            pulses    <= pulses + 1;
            last_id   <= int'(sel_id);
            pulse_cyc <= cyc;
            if (prev_sv === 1'b1) b2b <= b2b + 1;
        end
        prev_sv <= sel_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic place(input int x, input int y);
        mouse_x = 10'(x);
        mouse_y = 10'(y);
        tick(1);
    endtask

    task automatic click(input int hold);
        mouse_l = 1'b1;
        tick(hold);
        mouse_l = 1'b0;
        tick(12);
    endtask

    int p0;
    int t0;

    initial begin
        rst = 1'b1; state = 4'd0; mouse_x = '0; mouse_y = '0; mouse_l = 1'b0; play_valid = 4'd0;
        tick(3);
        rst = 1'b0;
        check("rst_hover", 32'(hover_id), 0);
        check("rst_sel_valid", 32'(sel_valid), 0);
        check("rst_sel_id", 32'(sel_id), 0);

        // Hit-map edges: [lo,hi) in the halved grid, no wrap at the screen corner.
        place(240, 240); check("edge_lo_stage1", 32'(hover_id), 1);
        place(399, 279); check("edge_hi_in", 32'(hover_id), 1);
        place(400, 240); check("edge_x_hi_out", 32'(hover_id), 0);
        place(639, 479); check("corner", 32'(hover_id), 0);
        state = 4'd9;
        place(280, 400); check("help_back_lo", 32'(hover_id), 6);
        place(438, 438); check("help_back_hi", 32'(hover_id), 6);
        place(278, 400); check("help_back_out", 32'(hover_id), 0);
        state = 4'd12;
        place(320, 260); check("undef_state", 32'(hover_id), 0);
        state = 4'd2;
        place(320, 260); check("stage_screen", 32'(hover_id), 0);
        state = 4'd0;

`ifdef UI_SELECT_ON_PRESS_EN
        place(320, 440); check("p_help_hover", 32'(hover_id), 4);
        p0 = pulses;
        mouse_l = 1'b1; t0 = cyc;
        tick(12);
        check("p_help_pulses", 32'(pulses - p0), 1);
        check("p_help_id", 32'(last_id), 4);
        check("p_help_latency", 32'(pulse_cyc - t0), 7);
        mouse_l = 1'b0;
        tick(12);
        check("p_release_ignored", 32'(pulses - p0), 1);
        place(0, 0); p0 = pulses; click(10);
        check("p_none_no_pulse", 32'(pulses - p0), 0);
        place(320, 260); p0 = pulses; click(10);
        check("p_stage1_id", 32'(last_id), 1);
        check("p_stage1_pulses", 32'(pulses - p0), 1);
`else
        // 1: click STAGE1, pulse 7 cycles after release
        place(320, 260); check("t1_hover", 32'(hover_id), 1);
        p0 = pulses;
        mouse_l = 1'b1; tick(20);
        mouse_l = 1'b0; t0 = cyc;
        tick(12);
        check("t1_pulses", 32'(pulses - p0), 1);
        check("t1_id", 32'(last_id), 1);
        check("t1_latency", 32'(pulse_cyc - t0), 7);
        check("t1_sv_low", 32'(sel_valid), 0);
        check("t1_id_hold", 32'(sel_id), 1);

        // 2: STAGE2 locked, then unlocked
        place(320, 320); check("t2_locked_hover", 32'(hover_id), 0);
        p0 = pulses; click(10);
        check("t2_locked_pulses", 32'(pulses - p0), 0);
        play_valid = 4'b0100;
        tick(1); check("t2_unlocked_hover", 32'(hover_id), 2);
        p0 = pulses; click(10);
        check("t2_pulses", 32'(pulses - p0), 1);
        check("t2_id", 32'(last_id), 2);
        play_valid = 4'd0;

        // 3: drag-off cancels, next click on BACK selects
        state = 4'd8;
        place(320, 300); check("t3_retry_hover", 32'(hover_id), 7);
        p0 = pulses;
        mouse_l = 1'b1; tick(10);
        place(320, 380); check("t3_back_hover", 32'(hover_id), 6);
        tick(5);
        mouse_l = 1'b0; tick(12);
        check("t3_drag_pulses", 32'(pulses - p0), 0);
        p0 = pulses; click(10);
        check("t3_back_pulses", 32'(pulses - p0), 1);
        check("t3_back_id", 32'(last_id), 6);

        // 4: screen change while armed cancels
        state = 4'd3;
        place(320, 300); check("t4_next_hover", 32'(hover_id), 5);
        p0 = pulses;
        mouse_l = 1'b1; tick(10);
        state = 4'd4; tick(5);
        mouse_l = 1'b0; tick(12);
        check("t4_pulses", 32'(pulses - p0), 0);
        check("t4_hover", 32'(hover_id), 0);
        state = 4'd3; tick(1);
        p0 = pulses; click(10);
        check("t4_recover_id", 32'(last_id), 5);
        check("t4_recover_pulses", 32'(pulses - p0), 1);

        // 5: bouncing input never settles
        state = 4'd0;
        place(320, 260);
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            mouse_l = ~mouse_l;
            tick(2);
        end
        mouse_l = 1'b0; tick(12);
        check("t5_bounce_pulses", 32'(pulses - p0), 0);
        p0 = pulses; click(10);
        check("t5_after_id", 32'(last_id), 1);
        check("t5_after_pulses", 32'(pulses - p0), 1);

        // 6: reset while armed on HELP
        place(320, 440); check("t6_help_hover", 32'(hover_id), 4);
        p0 = pulses;
        mouse_l = 1'b1; tick(10);
        rst = 1'b1; tick(1);
        rst = 1'b0; mouse_l = 1'b0;
        check("t6_rst_hover", 32'(hover_id), 0);
        check("t6_rst_sv", 32'(sel_valid), 0);
        check("t6_rst_id", 32'(sel_id), 0);
        tick(12);
        check("t6_pulses", 32'(pulses - p0), 0);
        check("t6_hover_back", 32'(hover_id), 4);
`endif
        check("no_back_to_back", 32'(b2b), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
